text_screen_writer: RTL and testbench

TEXT_SCREEN_WRITER -- requirements
Module: text_screen_writer

---
 rtl/text_screen_writer_if.sv | 21 ++
 rtl/text_screen_writer.sv | 145 ++++++++++++++
 tb/tb_text_screen_writer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_screen_writer_if.sv
// Character stream handshake into the text screen writer.
// One character moves on every edge where char_valid and char_ready are both high.
interface text_screen_writer_if #(
    parameter int DATA_WIDTH = 7
);
    logic                  char_valid;
    logic [DATA_WIDTH-1:0] char_data;
    logic                  char_ready;

    modport master (
        output char_valid,
        output char_data,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        output char_ready
    );
endinterface

// File: rtl/text_screen_writer.sv
// Terminal-style character writer for a row-major text RAM.
// Tracks a cursor, handles CR/LF/BS/FF, and sweeps the screen with spaces on clear.
module text_screen_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int X_WIDTH    = 7,
    parameter int Y_WIDTH    = 5,
    parameter int DATA_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    text_screen_writer_if.slave        chr,
    input  logic                       clr_req,
    output logic                       we,
    output logic [Y_WIDTH+X_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0]      din_a,
    output logic [X_WIDTH-1:0]         cur_x,
    output logic [Y_WIDTH-1:0]         cur_y,
    output logic                       busy
);
    typedef enum logic {IDLE, CLEAR} state_e;

    localparam logic [X_WIDTH-1:0]    X_LAST = X_WIDTH'(COLS - 1);
    localparam logic [Y_WIDTH-1:0]    Y_LAST = Y_WIDTH'(ROWS - 1);
    localparam logic [DATA_WIDTH-1:0] SPACE  = DATA_WIDTH'(32);
    localparam logic [DATA_WIDTH-1:0] TILDE  = DATA_WIDTH'(126);
    localparam logic [DATA_WIDTH-1:0] C_BS   = DATA_WIDTH'(8);
    localparam logic [DATA_WIDTH-1:0] C_LF   = DATA_WIDTH'(10);
    localparam logic [DATA_WIDTH-1:0] C_FF   = DATA_WIDTH'(12);
    localparam logic [DATA_WIDTH-1:0] C_CR   = DATA_WIDTH'(13);
    // Sweep position following the first clear write at {0,0}.
    localparam logic [X_WIDTH-1:0]    SX1    = (COLS == 1) ? '0 : X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0]    SY1    = (COLS == 1 && ROWS > 1) ? Y_WIDTH'(1) : '0;
    localparam logic                  LAST1  = (COLS * ROWS == 1);

    state_e                     state_q;
    logic [X_WIDTH-1:0]         cx_q, sx_q;
    logic [Y_WIDTH-1:0]         cy_q, sy_q;
    logic                       last_q;
    logic                       we_q, busy_q;
    logic [Y_WIDTH+X_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]      din_q;

    logic                       xfer;
    logic [DATA_WIDTH-1:0]      code;
    logic                       is_print, is_cr, is_lf, is_bs, is_ff;
    logic [X_WIDTH-1:0]         cx_d;
    logic [Y_WIDTH-1:0]         cy_d;

    assign chr.char_ready = (state_q == IDLE) && !clr_req;
    assign xfer           = chr.char_valid && chr.char_ready;
    assign code           = chr.char_data;

    assign is_print = (code >= SPACE) && (code <= TILDE);
    assign is_cr    = (code == C_CR);
    assign is_lf    = (code == C_LF);
    assign is_bs    = (code == C_BS);
    assign is_ff    = (code == C_FF);

    assign cx_d = (cx_q == X_LAST) ? '0 : cx_q + X_WIDTH'(1);
    assign cy_d = (cy_q == Y_LAST) ? '0 : cy_q + Y_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_req || (xfer && is_ff)) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        din_q   <= SPACE;
                        sx_q    <= SX1;
                        sy_q    <= SY1;
                        last_q  <= LAST1;
                    end else if (xfer) begin
                        unique case (1'b1)
                            is_print: begin
                                we_q   <= 1'b1;
                                addr_q <= {cy_q, cx_q};
                                din_q  <= code;
                                cx_q   <= cx_d;
                                if (cx_q == X_LAST) cy_q <= cy_d;
                            end
                            is_cr: cx_q <= '0;
                            is_lf: begin
                                cx_q <= '0;
                                cy_q <= cy_d;
                            end
                            is_bs: begin
                                if (cx_q != '0) begin
                                    we_q   <= 1'b1;
                                    addr_q <= {cy_q, cx_q - X_WIDTH'(1)};
                                    din_q  <= SPACE;
                                    cx_q   <= cx_q - X_WIDTH'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= {sy_q, sx_q};
                        din_q  <= SPACE;
                        last_q <= (sy_q == Y_LAST) && (sx_q == X_LAST);
                        if (sx_q == X_LAST) begin
                            sx_q <= '0;
                            sy_q <= (sy_q == Y_LAST) ? '0 : sy_q + Y_WIDTH'(1);
                        end else begin
                            sx_q <= sx_q + X_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we     = we_q;
    assign addr_a = addr_q;
    assign din_a  = din_q;
    assign cur_x  = cx_q;
    assign cur_y  = cy_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_text_screen_writer.sv
// Directed bench for text_screen_writer at the default 80x30 geometry.
module tb_text_screen_writer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr_req = 1'b0;
    logic        we;
    logic [11:0] addr_a;
    logic [6:0]  din_a;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

    text_screen_writer_if #(.DATA_WIDTH(7)) cif ();

    text_screen_writer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .chr     (cif),
        .clr_req (clr_req),
        .we      (we),
        .addr_a  (addr_a),
        .din_a   (din_a),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        clr_req = 1'b0;
        cif.char_valid = 1'b0;
        cif.char_data = 7'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One-cycle transfer; returns 1 time unit after the accepting edge.
    task automatic put(input logic [6:0] c);
        @(negedge clk);
        cif.char_valid = 1'b1;
        cif.char_data = c;
        @(posedge clk);
        #1;
        cif.char_valid = 1'b0;
    endtask

    task automatic put_n(input logic [6:0] c, input int n);
        for (int i = 0; i < n; i++) put(c);
    endtask

    task automatic test_reset();
        do_reset();
        put(7'h41);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({we, addr_a, din_a} !== 20'h0) begin
            fails++;
            $display("FAIL reset_write: we=%b addr=%h din=%h want 0/000/00", we, addr_a, din_a);
        end
        tests++;
        if ({cur_x, cur_y, busy, cif.char_ready} !== {7'd0, 5'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: x=%0d y=%0d busy=%b rdy=%b want 0 0 0 1",
                     cur_x, cur_y, busy, cif.char_ready);
        end
    endtask

    task automatic test_back_to_back();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cif.char_valid = 1'b1;
        cif.char_data = 7'h41;
        @(posedge clk);
        #1;
        tests++;
        if ({we, addr_a, din_a} !== {1'b1, 12'h000, 7'h41}) begin
            fails++;
            $display("FAIL ab_first: we=%b addr=%h din=%h want 1/000/41", we, addr_a, din_a);
        end
        cif.char_data = 7'h42;
        @(posedge clk);
        #1;
        cif.char_valid = 1'b0;
        tests++;
        if ({we, addr_a, din_a} !== {1'b1, 12'h001, 7'h42}) begin
            fails++;
            $display("FAIL ab_second: we=%b addr=%h din=%h want 1/001/42", we, addr_a, din_a);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd2, 5'd0}) begin
            fails++;
            $display("FAIL ab_after: we=%b x=%0d y=%0d want 0 2 0", we, cur_x, cur_y);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        put_n(7'h0A, 29);
        put_n(7'h78, 79);
        tests++;
        if ({cur_x, cur_y} !== {7'd79, 5'd29}) begin
            fails++;
            $display("FAIL wrap_pos: x=%0d y=%0d want 79 29", cur_x, cur_y);
        end
        put(7'h5A);
        tests++;
        if ({we, addr_a, din_a} !== {1'b1, 12'hECF, 7'h5A}) begin
            fails++;
            $display("FAIL wrap_write: we=%b addr=%h din=%h want 1/ecf/5a", we, addr_a, din_a);
        end
        tests++;
        if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin
            fails++;
            $display("FAIL wrap_cursor: x=%0d y=%0d want 0 0", cur_x, cur_y);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        put_n(7'h0A, 3);
        put_n(7'h61, 5);
        put(7'h08);
        tests++;
        if ({we, addr_a, din_a, cur_x, cur_y} !== {1'b1, 12'h184, 7'h20, 7'd4, 5'd3}) begin
            fails++;
            $display("FAIL bs_write: we=%b addr=%h din=%h x=%0d y=%0d want 1/184/20 4 3",
                     we, addr_a, din_a, cur_x, cur_y);
        end
        put(7'h0D);
        put(7'h08);
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd0, 5'd3}) begin
            fails++;
            $display("FAIL bs_col0: we=%b x=%0d y=%0d want 0 0 3", we, cur_x, cur_y);
        end
    endtask

    task automatic test_controls();
        do_reset();
        put_n(7'h0A, 4);
        put_n(7'h62, 10);
        put(7'h0D);
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd0, 5'd4}) begin
            fails++;
            $display("FAIL cr: we=%b x=%0d y=%0d want 0 0 4", we, cur_x, cur_y);
        end
        put_n(7'h0A, 25);
        put_n(7'h63, 10);
        put(7'h0A);
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd0, 5'd0}) begin
            fails++;
            $display("FAIL lf_wrap: we=%b x=%0d y=%0d want 0 0 0", we, cur_x, cur_y);
        end
        put(7'h63);
        put(7'h07);
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd1, 5'd0}) begin
            fails++;
            $display("FAIL bel_ignored: we=%b x=%0d y=%0d want 0 1 0", we, cur_x, cur_y);
        end
        put(7'h7F);
        tests++;
        if ({we, cur_x, cur_y} !== {1'b0, 7'd1, 5'd0}) begin
            fails++;
            $display("FAIL del_ignored: we=%b x=%0d y=%0d want 0 1 0", we, cur_x, cur_y);
        end
    endtask

    task automatic test_clear();
        int          writes;
        int          busyc;
        int          order_err;
        int          hold_err;
        logic [11:0] ea;
        do_reset();
        put(7'h61);
        put(7'h62);
        put(7'h63);
        @(negedge clk);
        clr_req = 1'b1;
        cif.char_valid = 1'b1;
        cif.char_data = 7'h51;
        #1;
        tests++;
        if (cif.char_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_ready_drop: rdy=%b want 0", cif.char_ready);
        end
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        cif.char_valid = 1'b0;
        writes = 0;
        busyc = 0;
        order_err = 0;
        hold_err = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!we) break;
            ea = {5'(writes / 80), 7'(writes % 80)};
            if (addr_a !== ea || din_a !== 7'h20) order_err++;
            if (busy) busyc++;
            if (cur_x !== 7'd3 || cur_y !== 5'd0) hold_err++;
            writes++;
            clr_req = (c == 500);
            @(posedge clk);
            #1;
        end
        clr_req = 1'b0;
        tests++;
        if (writes !== 2400) begin
            fails++;
            $display("FAIL clr_count: got %0d writes want 2400", writes);
        end
        tests++;
        if (order_err !== 0) begin
            fails++;
            $display("FAIL clr_order: %0d bad addr/data writes want 0", order_err);
        end
        tests++;
        if (busyc !== 2400 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_busy: busy cycles %0d, busy after %b want 2400 0", busyc, busy);
        end
        tests++;
        if (hold_err !== 0) begin
            fails++;
            $display("FAIL clr_hold: %0d cycles cursor moved want 0", hold_err);
        end
        tests++;
        if ({cur_x, cur_y, cif.char_ready} !== {7'd0, 5'd0, 1'b1}) begin
            fails++;
            $display("FAIL clr_end: x=%0d y=%0d rdy=%b want 0 0 1", cur_x, cur_y, cif.char_ready);
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        int stray;
        do_reset();
        put(7'h0C);
        tests++;
        if ({we, addr_a, din_a, busy} !== {1'b1, 12'h000, 7'h20, 1'b1}) begin
            fails++;
            $display("FAIL ff_clear: we=%b addr=%h din=%h busy=%b want 1/000/20 1",
                     we, addr_a, din_a, busy);
        end
        n = 1;
        for (int c = 0; c < 200 && n < 100; c++) begin
            @(posedge clk);
            #1;
            if (we) n++;
        end
        tests++;
        if (n !== 100) begin
            fails++;
            $display("FAIL midclr_progress: got %0d writes want 100", n);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({we, busy, cif.char_ready} !== 3'b001) begin
            fails++;
            $display("FAIL midclr_abort: we=%b busy=%b rdy=%b want 0 0 1", we, busy, cif.char_ready);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (we || busy) stray++;
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL midclr_quiet: %0d active cycles after release want 0", stray);
        end
        put(7'h5A);
        tests++;
        if ({we, addr_a, din_a} !== {1'b1, 12'h000, 7'h5A}) begin
            fails++;
            $display("FAIL midclr_resume: we=%b addr=%h din=%h want 1/000/5a", we, addr_a, din_a);
        end
    endtask

    initial begin
        cif.char_valid = 1'b0;
        cif.char_data = 7'h00;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_backspace();
        test_controls();
        test_clear();
        test_reset_midclear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
